// File: rtl/w0rm_core_inst_mem_port_pkg.sv
// Shared definitions for the instruction-fetch memory port: state encoding,
// fault causes and a width helper.
package w0rm_core_inst_mem_port_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StDrain = 3'd3,
    StResp  = 3'd4
  } state_e;

  localparam logic FaultMisalign = 1'b0;
  localparam logic FaultTimeout  = 1'b1;

  // Bits needed to index `value` entries, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/w0rm_core_inst_line_buf.sv
// One-word instruction line buffer: word-address tag, stored word and halfword lane mux.
// Instantiated by the port only when W0RM_INST_LINE_BUFFER_EN is defined.
module w0rm_core_inst_line_buf
  import w0rm_core_inst_mem_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 16,
  parameter int unsigned TAG_WIDTH  = 30,
  parameter int unsigned OFF_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fill,
  input  logic [TAG_WIDTH-1:0]  fill_tag,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  input  logic [OFF_WIDTH-1:0]  lookup_off,
  output logic                  hit,
  output logic [INST_WIDTH-1:0] inst
);
  localparam int unsigned SubW = $clog2(INST_WIDTH / 8);

  logic                  valid_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [OFF_WIDTH-1:0]  lane;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else if (fill) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      word_q  <= fill_data;
    end
  end

  assign lane = lookup_off >> SubW;
  assign hit  = valid_q && (tag_q == lookup_tag);
  assign inst = word_q[lane * INST_WIDTH +: INST_WIDTH];

endmodule

// File: rtl/w0rm_core_inst_mem_port.sv
// Instruction-fetch responder: one outstanding bus read per PC request, flush-aware.
// Optional one-word line buffer enabled by defining W0RM_INST_LINE_BUFFER_EN.
module w0rm_core_inst_mem_port
  import w0rm_core_inst_mem_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned INST_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  pc_valid_in,
  input  logic                  flush,
  output logic [INST_WIDTH-1:0] inst_data_out,
  output logic                  inst_valid_out,
  output logic                  inst_fault_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);
  localparam int unsigned OffW = clog2_min1(DATA_WIDTH / 8);
  localparam int unsigned SubW = $clog2(INST_WIDTH / 8);
  localparam int unsigned CntW = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [OffW-1:0]       off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INST_WIDTH-1:0] data_q, data_d;
  logic                  fault_q, fault_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [OffW-1:0]       lane;
  logic [INST_WIDTH-1:0] lane_inst;
  logic                  expired;
  logic                  buf_hit;
  logic [INST_WIDTH-1:0] buf_inst;

`ifdef W0RM_INST_LINE_BUFFER_EN
  w0rm_core_inst_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .INST_WIDTH(INST_WIDTH),
    .TAG_WIDTH (ADDR_WIDTH - OffW),
    .OFF_WIDTH (OffW)
  ) u_line_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .fill      (mem_rvalid),
    .fill_tag  (addr_q[ADDR_WIDTH-1:OffW]),
    .fill_data (mem_rdata),
    .lookup_tag(pc_in[ADDR_WIDTH-1:OffW]),
    .lookup_off(pc_in[OffW-1:0]),
    .hit       (buf_hit),
    .inst      (buf_inst)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_inst = '0;
`endif

  assign lane      = off_q >> SubW;
  assign lane_inst = mem_rdata[lane * INST_WIDTH +: INST_WIDTH];
  // A zero timeout parameter means the counter never expires.
  assign expired   = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fault_d = fault_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (pc_valid_in && !flush) begin
          off_d = pc_in[OffW-1:0];
          if (pc_in[0]) begin
            state_d = StResp;
            fault_d = 1'b1;
            data_d  = '0;
          end else if (buf_hit) begin
            state_d = StResp;
            fault_d = 1'b0;
            data_d  = buf_inst;
          end else begin
            state_d            = StReq;
            addr_d             = pc_in;
            addr_d[OffW-1:0]   = '0;
          end
        end
      end
      StReq: begin
        if (flush) state_d = StIdle;
        else if (mem_ready) state_d = StWait;
      end
      StWait: begin
        if (flush) begin
          // Data arriving on the flush edge is already consumed; nothing left to drain.
          state_d = mem_rvalid ? StIdle : StDrain;
        end else if (mem_rvalid) begin
          state_d = StResp;
          fault_d = 1'b0;
          data_d  = lane_inst;
        end else if (expired) begin
          state_d = StResp;
          fault_d = 1'b1;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (mem_rvalid || expired) state_d = StIdle;
        else cnt_d = cnt_q + 1'b1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      off_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req        = (state_q == StReq) && !flush;
  assign mem_addr       = addr_q;
  assign inst_data_out  = data_q;
  assign inst_valid_out = (state_q == StResp) && !flush;
  assign inst_fault_out = fault_q && !((state_q == StResp) && flush);

endmodule

// File: tb/tb_w0rm_core_inst_mem_port.sv
// Randomized self-checking bench for w0rm_core_inst_mem_port with a transaction-level model.
// Honours W0RM_INST_LINE_BUFFER_EN when predicting buffer hits.
module tb_w0rm_core_inst_mem_port;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_in;
  logic        pc_valid_in, flush;
  logic [15:0] inst_data_out;
  logic        inst_valid_out, inst_fault_out;
  logic [31:0] mem_addr;
  logic        mem_req, mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  w0rm_core_inst_mem_port #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .INST_WIDTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .pc_valid_in(pc_valid_in), .flush(flush),
    .inst_data_out(inst_data_out), .inst_valid_out(inst_valid_out),
    .inst_fault_out(inst_fault_out), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle expectations produced by the stimulus model.
  logic        chk_en = 1'b0;
  logic        exp_valid, exp_fault, exp_req, exp_fmask;
  logic [15:0] exp_data;
  logic [31:0] exp_addr;
  // Observations for literal checks.
  logic [15:0] last_data;
  logic        last_fault;
  logic [31:0] last_req_addr;
  int          nstrobe = 0, nreq = 0, strobe_cyc = 0, acc_cyc = 0;
  // Line buffer model.
  logic        buf_valid = 1'b0;
  logic [31:0] buf_tag, buf_word, last_addr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("inst_valid_out", inst_valid_out, exp_valid);
      if (exp_valid) begin
        chk("inst_data_out", inst_data_out, exp_data);
        chk("inst_fault_out", inst_fault_out, exp_fault);
      end
      if (exp_fmask) chk("fault_masked_by_flush", inst_fault_out, 0);
      chk("mem_req", mem_req, exp_req);
      if (exp_req) chk("mem_addr", mem_addr, exp_addr);
      if (inst_valid_out) begin
        last_data  = inst_data_out;
        last_fault = inst_fault_out;
        strobe_cyc = cyc;
        nstrobe++;
      end
      if (mem_req) begin
        last_req_addr = mem_addr;
        nreq++;
      end
    end
  end

  function automatic logic [15:0] lane(input logic [31:0] w, input logic [31:0] pc);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pc_valid_in = 1'b0; pc_in = $urandom; flush = 1'b0;
    mem_ready = 1'($urandom); mem_rvalid = 1'b0; mem_rdata = $urandom;
    exp_valid = 1'b0; exp_req = 1'b0; exp_fmask = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      tick();
    end
  endtask

  task automatic fill(input logic [31:0] data);
    buf_valid = 1'b1; buf_tag = last_addr; buf_word = data;
  endtask

  // Response cycle; a PC presented here must be ignored.
  task automatic resp(input logic fault, input logic [15:0] data, input logic fl);
    set_idle();
    pc_valid_in = 1'b1;
    exp_valid = !fl; exp_fault = fault; exp_data = data;
    flush = fl; exp_fmask = fl;
    tick();
  endtask

  // fmode: 0 none, 1 flush at REQ cycle fpos, 2 flush at WAIT cycle fpos, 3 flush in RESP.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] rdata, input int rdy_wait,
                       input int rv_wait, input int fmode, input int fpos);
    logic [31:0] aligned;
    aligned = {pc[31:2], 2'b00};
    set_idle();
    pc_valid_in = 1'b1; pc_in = pc; acc_cyc = cyc;
    tick();
    if (pc[0]) begin
      resp(1'b1, 16'h0, fmode == 3);
      return;
    end
`ifdef W0RM_INST_LINE_BUFFER_EN
    if (buf_valid && buf_tag == aligned) begin
      resp(1'b0, lane(buf_word, pc), fmode == 3);
      return;
    end
`endif
    for (int i = 0; ; i++) begin
      set_idle();
      if (fmode == 1 && i == fpos) begin
        flush = 1'b1;
        tick();
        return;
      end
      exp_req = 1'b1; exp_addr = aligned;
      mem_ready = (i >= rdy_wait);
      tick();
      if (i >= rdy_wait) break;
    end
    last_addr = aligned;
    for (int w = 0; ; w++) begin
      set_idle();
      if (fmode == 2 && w == fpos) begin
        flush = 1'b1;
        tick();
        for (int d = w + 1; d <= rv_wait; d++) begin
          set_idle();
          if (d == rv_wait) begin
            mem_rvalid = 1'b1; mem_rdata = rdata; fill(rdata);
          end
          tick();
        end
        return;
      end
      if (w == rv_wait) begin
        mem_rvalid = 1'b1; mem_rdata = rdata; fill(rdata);
        tick();
        resp(1'b0, lane(rdata, pc), fmode == 3);
        return;
      end
      if (w == int'(TO) - 1) begin
        tick();
        resp(1'b1, 16'h0, fmode == 3);
        return;
      end
      tick();
    end
  endtask

  task automatic late_rvalid(input logic [31:0] data);
    set_idle();
    mem_rvalid = 1'b1; mem_rdata = data; fill(data);
    tick();
  endtask

  // Called mid-cycle: reset must clear outputs without waiting for an edge.
  task automatic async_reset();
    #2;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valid", inst_valid_out, 0);
    chk("rst_fault", inst_fault_out, 0);
    chk("rst_addr", mem_addr, 0);
    buf_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_idle();
    chk_en = 1'b1;
  endtask

  int n0, r0;

  initial begin
    set_idle();
    #3;
    chk("por_valid", inst_valid_out, 0);
    chk("por_fault", inst_fault_out, 0);
    chk("por_data", inst_data_out, 0);
    chk("por_req", mem_req, 0);
    chk("por_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Basic miss.
    n0 = nstrobe; r0 = nreq;
    fetch(32'h2000_0000, 32'hBEEF_1234, 0, 0, 0, 0);
    idle(1);
    chk("t1_data", last_data, 16'h1234);
    chk("t1_fault", last_fault, 0);
    chk("t1_req_cycles", nreq - r0, 1);
    chk("t1_strobes", nstrobe - n0, 1);
    chk("t1_latency", strobe_cyc - acc_cyc, 3);

    // Upper halfword of the same word: buffer hit or a fresh bus read.
    r0 = nreq;
    fetch(32'h2000_0002, 32'hBEEF_1234, 0, 0, 0, 0);
    idle(1);
    chk("t2_data", last_data, 16'hBEEF);
`ifdef W0RM_INST_LINE_BUFFER_EN
    chk("t2_req_cycles", nreq - r0, 0);
    chk("t2_latency", strobe_cyc - acc_cyc, 1);
`else
    chk("t2_req_cycles", nreq - r0, 1);
    chk("t2_addr", last_req_addr, 32'h2000_0000);
`endif

    // Flush in WAIT, data 3 cycles later is dropped; then a normal fetch.
    n0 = nstrobe;
    fetch(32'h2000_0040, 32'h5555_6666, 0, 3, 2, 0);
    idle(2);
    chk("t3_no_strobe", nstrobe - n0, 0);
    fetch(32'h2000_0100, 32'hCAFE_F00D, 1, 1, 0, 0);
    idle(1);
    chk("t3_addr", last_req_addr, 32'h2000_0100);
    chk("t3_data", last_data, 16'hF00D);

    // Misaligned PC.
    r0 = nreq; n0 = nstrobe;
    fetch(32'h2000_0001, 32'h0, 0, 0, 0, 0);
    idle(1);
    chk("t4_fault", last_fault, 1);
    chk("t4_data", last_data, 0);
    chk("t4_req_cycles", nreq - r0, 0);
    chk("t4_strobes", nstrobe - n0, 1);

    // Timeout, then a late rvalid that must not strobe.
    fetch(32'h2000_0200, 32'h0, 0, 5, 0, 0);
    chk("t5_fault", last_fault, 1);
    chk("t5_latency", strobe_cyc - acc_cyc, 6);
    n0 = nstrobe;
    late_rvalid(32'h7777_8888);
    idle(2);
    chk("t5_late_rvalid", nstrobe - n0, 0);

    // Flush beats pc_valid in IDLE.
    r0 = nreq; n0 = nstrobe;
    set_idle(); pc_valid_in = 1'b1; pc_in = 32'h2000_0300; flush = 1'b1;
    tick();
    idle(2);
    chk("t6_req_cycles", nreq - r0, 0);
    chk("t6_strobes", nstrobe - n0, 0);

    // Flush during RESP masks the strobe.
    n0 = nstrobe;
    fetch(32'h2000_0005, 32'h0, 0, 0, 3, 0);
    idle(1);
    chk("t7_masked", nstrobe - n0, 0);

    // Async reset during RESP, then during WAIT.
    set_idle(); pc_valid_in = 1'b1; pc_in = 32'h2000_0011;
    tick();
    set_idle();
    #2;
    chk("t8_valid_pre_reset", inst_valid_out, 1);
    #(-0);
    async_reset();
    idle(1);
    fetch(32'h2000_0400, 32'h1111_2222, 0, 0, 0, 0);
    idle(1);
    set_idle(); pc_valid_in = 1'b1; pc_in = 32'h2000_0500;
    tick();
    set_idle(); exp_req = 1'b1; exp_addr = 32'h2000_0500; mem_ready = 1'b1;
    tick();
    set_idle();
    async_reset();
    idle(1);
    r0 = nreq;
    fetch(32'h2000_0402, 32'h3333_4444, 0, 0, 0, 0);
    idle(1);
    chk("t8_miss_after_reset", nreq - r0, 1);
    chk("t8_data", last_data, 16'h3333);

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      logic [31:0] pc;
      int rdy, rv, fm, fp, sel;
      pc  = 32'h2000_0000 + 32'(($urandom % 4) * 4) + 32'($urandom % 4);
      rdy = $urandom % 3;
      rv  = ($urandom % 10 == 0) ? 5 : int'($urandom % 4);
      sel = $urandom % 10;
      fm = 0; fp = 0;
      if (sel == 1) begin
        fm = 1; fp = $urandom % (rdy + 1);
      end else if (sel == 2 && rv >= 1 && rv < int'(TO)) begin
        fm = 2; fp = $urandom % rv;
      end else if (sel == 3) begin
        fm = 3;
      end
      fetch(pc, $urandom, rdy, rv, fm, fp);
      if (rv >= int'(TO) && fm == 0 && !pc[0] && $urandom % 2 == 1) late_rvalid($urandom);
      if ($urandom % 8 == 0) begin
        set_idle(); pc_valid_in = 1'b1; flush = 1'b1;
        tick();
      end
      idle(1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
